// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI master controller.
//               - spi_state_e : transfer state machine encoding
//               - MODE_*_BIT  : bit positions of CPOL/CPHA in a packed mode field
//               - edge_width  : width of the SCK edge counter for a word width
//               - sel_width   : width of the chip-select index (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    // Packed mode field layout used by the host register file: {CPOL, CPHA}.
    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;

    // Edge counter must hold 0..2*DATA_W.
    function automatic int edge_width(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

    function automatic int sel_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clkgen
// Description : Half-period tick generator for the SPI master. A DIV_W-bit
//               down-counter emits a one-cycle tick every i_div+1 cycles
//               while enabled and reloads from i_div when enable rises.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_en            - enable (next-cycle activity of the FSM)
//               i_div           - half-period length minus one
//               o_half_tick     - one-cycle pulse on the last cycle of a half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_half_tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // i_en is the FSM's next-state activity, so the counter is already loaded
    // with the divider on the first cycle of LEAD.
    always_comb begin
        active_d = i_en;
        cnt_d    = cnt_q;
        if (i_en && !active_q) begin
            cnt_d = i_div;
        end else if (active_q) begin
            // Wrap only at the end of a half-period, so div = all-ones is legal.
            cnt_d = (cnt_q == '0) ? i_div : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign o_half_tick = active_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : Parametrised SPI master. Word width, divider, CPOL/CPHA,
//               bit order and chip select are latched when a start request
//               is accepted in IDLE. Chip selects may be held between words.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               txdata, txstart      - word and start request (idle only)
//               div                  - SCK half-period = div+1 clk cycles
//               cpol, cpha, lsb_first- SPI mode and bit order
//               cs_sel, cs_hold      - select index, keep CS low after word
//               cs_release           - idle pulse that raises all CS
//               rxdata, rxvalid      - received word and completion strobe
//               busy                 - transfer in progress
//               spi_sck/mosi/miso    - serial bus
//               spi_cs_n             - active-low chip selects
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            txdata,
    input  logic                         txstart,
    input  logic [DIV_W-1:0]             div,
    input  logic                         cpol,
    input  logic                         cpha,
    input  logic                         lsb_first,
    input  logic [sel_width(NUM_CS)-1:0] cs_sel,
    input  logic                         cs_hold,
    input  logic                         cs_release,
    output logic [DATA_W-1:0]            rxdata,
    output logic                         rxvalid,
    output logic                         busy,
    output logic                         spi_sck,
    output logic                         spi_mosi,
    input  logic                         spi_miso,
    output logic [NUM_CS-1:0]            spi_cs_n
);

    localparam int CS_W   = sel_width(NUM_CS);
    localparam int EDGE_W = edge_width(DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

    spi_state_e          state_q, state_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rxdata_q, rxdata_d;
    logic                rxvalid_q, rxvalid_d;
    logic                busy_q, busy_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                cs_hold_q, cs_hold_d;

    logic                half_tick;
    logic                do_edge;
    logic [EDGE_W-1:0]   next_edge;
    logic                edge_odd;
    logic                do_sample;
    logic                do_shift;
    logic [DATA_W-1:0]   tx_shifted;

    // Out-of-range selects leave every CS high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .i_en        (state_d != IDLE),
        .i_div       (div_d),
        .o_half_tick (half_tick)
    );

    assign next_edge = edge_q + EDGE_ONE;
    assign edge_odd  = next_edge[0];

    // CPHA=0: sample on leading (odd) edges, shift on trailing edges except
    // the last. CPHA=1: shift on leading edges after the first, sample on
    // trailing edges.
    assign do_sample = do_edge && (cpha_q ? !edge_odd : edge_odd);
    assign do_shift  = do_edge && (cpha_q ? (edge_odd && (next_edge != EDGE_ONE))
                                          : (!edge_odd && (next_edge != EDGE_LAST)));

    assign tx_shifted = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]}
                              : {tx_sh_q[DATA_W-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rxdata_d  = rxdata_q;
        rxvalid_d = 1'b0;
        busy_d    = busy_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        cs_hold_d = cs_hold_q;
        do_edge   = 1'b0;

        case (state_q)
            IDLE: begin
                if (txstart) begin
                    state_d   = LEAD;
                    busy_d    = 1'b1;
                    edge_d    = '0;
                    tx_sh_d   = txdata;
                    div_d     = div;
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    lsb_d     = lsb_first;
                    cs_hold_d = cs_hold;
                    sck_d     = cpol;
                    mosi_d    = lsb_first ? txdata[0] : txdata[DATA_W-1];
                    // Decoding the new select also raises any held CS.
                    cs_n_d    = cs_decode(cs_sel);
                end else if (cs_release) begin
                    cs_n_d = '1;
                end
            end
            LEAD: begin
                if (half_tick) begin
                    state_d = XFER;
                    edge_d  = next_edge;
                    sck_d   = !sck_q;
                    do_edge = 1'b1;
                end
            end
            XFER: begin
                if (half_tick) begin
                    if (edge_q == EDGE_LAST) begin
                        state_d = TRAIL;
                        sck_d   = cpol_q;
                    end else begin
                        edge_d  = next_edge;
                        sck_d   = !sck_q;
                        do_edge = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (half_tick) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    rxvalid_d = 1'b1;
                    rxdata_d  = rx_sh_q;
                    if (!cs_hold_q) begin
                        cs_n_d = '1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_sample) begin
            rx_sh_d = lsb_q ? {spi_miso, rx_sh_q[DATA_W-1:1]}
                            : {rx_sh_q[DATA_W-2:0], spi_miso};
        end
        if (do_shift) begin
            tx_sh_d = tx_shifted;
            mosi_d  = lsb_q ? tx_shifted[0] : tx_shifted[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            cs_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            busy_q    <= busy_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            div_q     <= div_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            cs_hold_q <= cs_hold_d;
        end
    end

    assign rxdata   = rxdata_q;
    assign rxvalid  = rxvalid_q;
    assign busy     = busy_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Parametrised SPI master with registered-interface control, the next-generation replacement for the fixed 8-bit, mode-0, two-speed SPI engine behind the host register file. It adds:
- configurable word width;
- a runtime clock divider;
- all four CPOL/CPHA modes and MSB/LSB-first ordering;
- NUM_CS chip selects with optional hold between words;
- a one-cycle `rxvalid` completion strobe.

## Interface
- `DATA_W`, 8, bits per transfer (≥2).
- `DIV_W`, 8, width of the divider input.
- `NUM_CS`, 2, number of active-low chip selects (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `txdata` in DATA_W: word to send, sampled on accept.
- `txstart` in 1: start request, accepted only when `busy`=0.
- `div` in DIV_W: SCK half-period = `div`+1 clk cycles, latched on accept.
- `cpol` in 1: SCK idle level, latched on accept.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge. Latched on accept.
- `lsb_first` in 1: bit order, latched on accept.
- `cs_sel` in clog2(NUM_CS) (min 1): chip select to assert, latched on accept.
- `cs_hold` in 1: keep CS asserted after this word, latched on accept.
- `cs_release` in 1: pulse while idle drops a held CS.
- `rxdata` out DATA_W: last received word, stable until next completion.
- `rxvalid` out 1: one-cycle pulse when `rxdata` updates.
- `busy` out 1: transfer in progress.
- `spi_sck` out 1: serial clock.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.
- `spi_cs_n` out NUM_CS: active-low chip selects.

## Operation
State machine has four states:
- **IDLE**: `txstart`=1 is accepted. It latches `txdata` into the TX shifter and latches the mode/divider/select inputs, then moves to LEAD.
- **LEAD**: one half-period.
  - `spi_cs_n[cs_sel]` driven low; every other CS driven high.
  - SCK at `cpol`.
  - MOSI presents the first bit: `txdata[DATA_W-1]`, or `[0]` if `lsb_first`.
- **XFER**: 2·DATA_W half-periods. SCK toggles at the start of each, giving edges k = 1..2·DATA_W.
  - `cpha`=0: sample MISO on odd k; shift MOSI on even k < 2·DATA_W.
  - `cpha`=1: shift MOSI on odd k > 1; sample MISO on even k.
  - RX shifter fills MSB-first or LSB-first per `lsb_first`.
- **TRAIL**: one half-period, SCK = `cpol`. On exit:
  - `rxdata` is loaded and `rxvalid`=1 for one cycle.
  - `busy`=0.
  - CS deasserts unless `cs_hold` was latched.
  - Return to IDLE.

CS hold rules:
- A held CS stays low through IDLE.
- A new accept with the same `cs_sel` keeps it low.
- A new accept with a different `cs_sel` raises the old CS and lowers the new one in the same cycle.
- `cs_release` while idle raises all CS next cycle. It is ignored while busy.

Other rules:
- `txstart` while busy is ignored, with no queueing.
- Out-of-range `cs_sel` asserts no CS; the transfer still runs.
- Inputs other than `spi_miso` and `cs_release` have no effect between accepts.

## Timing
Reset values, applied the cycle after `rst`=1, including mid-transfer:
- `busy`=0, `rxvalid`=0, `rxdata`=0.
- `spi_sck`=0, `spi_mosi`=0, `spi_cs_n` all 1.
- Latched `cpol`=0; state IDLE.

Cycle timing, with D = `div`+1 and accept at cycle 0:
- `busy`=1 from cycle 1 through cycle (2·DATA_W+2)·D.
- CS low from cycle 1.
- Edge k appears on `spi_sck` at cycle k·D+1.
- MISO is sampled on the clk edge that registers SCK edge k.
- `rxvalid`=1 and `busy`=0 at cycle (2·DATA_W+2)·D+1.
- Example: DATA_W=8, div=0 gives `rxvalid` at cycle 19.

Back-to-back and idle behaviour:
- A `txstart` in the `rxvalid` cycle is accepted; next LEAD starts the following cycle.
- Idle `spi_sck` equals the latched `cpol` of the most recent transfer.
- A new `cpol` takes effect at LEAD entry.
- `div` = 2^DIV_W−1 is legal; the divider counter wraps only at end of half-period.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, LEAD, XFER, TRAIL);
  - localparam `EDGE_W` = clog2(2·DATA_W+1);
  - mode bit positions (CPOL=1, CPHA=0) for register-file packing.
- Sub-module `spi_clkgen`:
  - DIV_W down-counter;
  - emits a one-cycle `half_tick` every D cycles while enabled;
  - reloads on enable rise.
- Top holds the FSM, edge counter, shifters and CS logic.

## Test plan
- Mode 0, DATA_W=8, div=0, `txdata`=0xA5, MISO loopback → MOSI bits 1,0,1,0,0,1,0,1 on falling edges; `rxdata`=0xA5; `rxvalid` at cycle 19.
- Mode 3, `lsb_first`=1, div=3, `txdata`=0x81, MISO driven 0x3C LSB-first → SCK idle high, 8 periods of 8 clk; `rxdata`=0x3C; `busy` for 72 cycles.
- `cs_hold`=1 on cs 0 for two words, then `cs_release` → `spi_cs_n[0]` low continuously across both words; high one cycle after release.
- `txstart` on the `rxvalid` cycle, plus a `txstart` mid-transfer → first accepted back-to-back; mid-transfer request ignored with no extra word.
- `rst` asserted at edge 5 of a transfer → next cycle `spi_cs_n`=all 1, `spi_sck`=0, `busy`=0, `rxdata`=0, no `rxvalid`.
- `cs_sel` switches 0→1 while cs 0 is held → cs 0 high and cs 1 low in the same cycle.
